// File: rtl/framer_pkg.sv
// -----------------------------------------------------------------------------
// framer_pkg
// Shared definitions for the 110101 sync-pattern frame transmitter:
//   state_t      - frame FSM states (IDLE, HDR, PAY, PAR, GAP)
//   HDR_LEN      - number of header bits
//   HDR_PATTERN  - header bits, sent MSB first
//   hdr_bit()    - header bit for a given header bit index
// -----------------------------------------------------------------------------
package framer_pkg;

   typedef enum logic [2:0] {IDLE, HDR, PAY, PAR, GAP} state_t;

   localparam int                 HDR_LEN     = 6;
   localparam logic [HDR_LEN-1:0] HDR_PATTERN = 6'b110101;

   // Index 0 is the first bit on the wire, i.e. the pattern MSB.
   function automatic logic hdr_bit(input logic [3:0] idx);
      logic [HDR_LEN-1:0] sh;
      sh = HDR_PATTERN << idx;
      return sh[HDR_LEN-1];
   endfunction

endpackage

// File: rtl/framer_110101_bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// 4-bit field bit counter used by the framer FSM.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   clk_en     - bit-time enable; count changes only when high
//   inc        - advance the count by one
//   clr        - return the count to zero (wins over inc)
//   term       - terminal value of the current field
//   count      - current bit index
//   co         - high when count equals term (last bit of the field)
// -----------------------------------------------------------------------------
module bit_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       inc,
   input  logic       clr,
   input  logic [3:0] term,
   output logic [3:0] count,
   output logic       co
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= 4'd0;
      end else if (clk_en) begin
         if (clr)
            count <= 4'd0;
         else if (inc)
            count <= count + 4'd1;
      end
   end

   assign co = (count == term);

endmodule

// File: rtl/framer_110101.sv
// -----------------------------------------------------------------------------
// framer_110101
// Serial frame transmitter: header 110101, payload MSB first, optional even
// parity bit, then GAP_LEN idle bits. Optional parity is enabled by defining
// the macro FRAMER_PARITY_EN.
// Ports:
//   clk            - system clock, rising edge
//   rst            - asynchronous active-low reset
//   clk_en         - bit-time enable; all state advances only when high
//   load           - request to send data_in (accepted while ready)
//   data_in        - payload word
//   ready          - high in IDLE, when a load will be accepted
//   ser_out        - registered serial data
//   ser_out_valid  - high while ser_out carries header, payload or parity
//   busy           - high from acceptance through the last gap bit
//   cnt_out        - bit index of ser_out within the current field
// -----------------------------------------------------------------------------
module framer_110101
   import framer_pkg::*;
#(
   parameter int PAYLOAD_W = 8,
   parameter int GAP_LEN   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 load,
   input  logic [PAYLOAD_W-1:0] data_in,
   output logic                 ready,
   output logic                 ser_out,
   output logic                 ser_out_valid,
   output logic                 busy,
   output logic [3:0]           cnt_out
);

   state_t               state;
   logic [PAYLOAD_W-1:0] shreg;
   logic [3:0]           term;
   logic                 co;
   logic                 cnt_clr;
   logic                 cnt_inc;
`ifdef FRAMER_PARITY_EN
   logic                 par;
`endif

   assign ready = (state == IDLE);
   assign busy  = (state != IDLE);

   // Terminal bit index of the field currently on ser_out.
   always_comb begin
      term = 4'd0;
      case (state)
         HDR:     term = 4'(HDR_LEN - 1);
         PAY:     term = 4'(PAYLOAD_W - 1);
         GAP:     term = 4'(GAP_LEN - 1);
         default: term = 4'd0;
      endcase
   end

   // Counter sits at zero in IDLE so the acceptance edge shows index 0, and
   // restarts at every field boundary.
   assign cnt_clr = (state == IDLE) || co;
   assign cnt_inc = (state != IDLE);

   bit_counter u_bit_counter (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .inc    (cnt_inc),
      .clr    (cnt_clr),
      .term   (term),
      .count  (cnt_out),
      .co     (co)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         ser_out       <= 1'b0;
         ser_out_valid <= 1'b0;
         shreg         <= '0;
`ifdef FRAMER_PARITY_EN
         par           <= 1'b0;
`endif
      end else if (clk_en) begin
         case (state)
            IDLE: begin
               if (load) begin
                  // Output register shows header bit 0 on the acceptance edge.
                  state         <= HDR;
                  shreg         <= data_in;
                  ser_out       <= hdr_bit(4'd0);
                  ser_out_valid <= 1'b1;
`ifdef FRAMER_PARITY_EN
                  par           <= 1'b0;
`endif
               end else begin
                  ser_out       <= 1'b0;
                  ser_out_valid <= 1'b0;
               end
            end

            HDR: begin
               if (co) begin
                  state   <= PAY;
                  ser_out <= shreg[PAYLOAD_W-1];
                  shreg   <= shreg << 1;
`ifdef FRAMER_PARITY_EN
                  par     <= par ^ shreg[PAYLOAD_W-1];
`endif
               end else begin
                  ser_out <= hdr_bit(cnt_out + 4'd1);
               end
            end

            PAY: begin
               if (co) begin
`ifdef FRAMER_PARITY_EN
                  // par already covers every payload bit sent so far.
                  state         <= PAR;
                  ser_out       <= par;
                  ser_out_valid <= 1'b1;
`else
                  state         <= GAP;
                  ser_out       <= 1'b0;
                  ser_out_valid <= 1'b0;
`endif
               end else begin
                  ser_out <= shreg[PAYLOAD_W-1];
                  shreg   <= shreg << 1;
`ifdef FRAMER_PARITY_EN
                  par     <= par ^ shreg[PAYLOAD_W-1];
`endif
               end
            end

            PAR: begin
               state         <= GAP;
               ser_out       <= 1'b0;
               ser_out_valid <= 1'b0;
            end

            GAP: begin
               ser_out       <= 1'b0;
               ser_out_valid <= 1'b0;
               if (co)
                  state <= IDLE;
            end

            default: begin
               state         <= IDLE;
               ser_out       <= 1'b0;
               ser_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_framer_110101.sv
// -----------------------------------------------------------------------------
// tb_framer_110101
// Directed testbench for framer_110101 (PAYLOAD_W=8, GAP_LEN=2). Define
// FRAMER_PARITY_EN for both the bench and the design to cover the parity build.
// -----------------------------------------------------------------------------
module tb_framer_110101;

   localparam int W   = 8;
   localparam int GAP = 2;
`ifdef FRAMER_PARITY_EN
   localparam int PN  = 1;
`else
   localparam int PN  = 0;
`endif
   localparam int FLEN = 6 + W + PN + GAP;

   logic         clk = 1'b0;
   logic         rst;
   logic         clk_en;
   logic         load;
   logic [W-1:0] data_in;
   logic         ready;
   logic         ser_out;
   logic         ser_out_valid;
   logic         busy;
   logic [3:0]   cnt_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   framer_110101 #(.PAYLOAD_W(W), .GAP_LEN(GAP)) dut (
      .clk           (clk),
      .rst           (rst),
      .clk_en        (clk_en),
      .load          (load),
      .data_in       (data_in),
      .ready         (ready),
      .ser_out       (ser_out),
      .ser_out_valid (ser_out_valid),
      .busy          (busy),
      .cnt_out       (cnt_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Frame bits, first bit on the wire in the most significant used position.
   function automatic logic [31:0] exp_frame(input logic [W-1:0] d);
      logic [31:0] f;
      f = 32'(6'b110101);
      for (int i = W - 1; i >= 0; i--) f = {f[30:0], d[i]};
      if (PN == 1) f = {f[30:0], ^d};
      for (int g = 0; g < GAP; g++) f = {f[30:0], 1'b0};
      return f;
   endfunction

   function automatic logic [3:0] exp_cnt(input int i);
      int j;
      j = i;
      if (j < 6) return 4'(j);
      j -= 6;
      if (j < W) return 4'(j);
      j -= W;
      if (PN == 1) begin
         if (j == 0) return 4'd0;
         j -= 1;
      end
      return 4'(j);
   endfunction

   // Sends one frame and checks it edge by edge. Edge 0 is the acceptance
   // edge; edge FLEN returns to IDLE. stretch applies clk_en = 1,0,0,1,0,0...
   // pulse_at >= 0 raises load for the single enabled edge with that index.
   task automatic send_and_check(input string tag, input logic [W-1:0] d,
                                 input logic [31:0] exp_ser, input bit stretch,
                                 input int pulse_at);
      logic [31:0] got_ser;
      logic [31:0] got_val;
      logic [31:0] exp_val;
      logic [7:0]  prev;
      bit          cnt_ok;
      bit          busy_ok;
      bit          hold_ok;
      int          nen;
      int          k;
      got_ser = '0;
      got_val = '0;
      exp_val = ((32'd1 << (FLEN - GAP)) - 32'd1) << GAP;
      cnt_ok  = 1'b1;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      nen     = 0;
      k       = 0;
      check({tag, "_ready_pre"}, 32'(ready), 32'd1);
      data_in = d;
      load    = 1'b1;
      while (nen < FLEN && k < 400) begin
         clk_en = stretch ? (k % 3 == 0) : 1'b1;
         prev   = {ser_out, ser_out_valid, busy, ready, cnt_out};
         step();
         if (clk_en) begin
            got_ser = {got_ser[30:0], ser_out};
            got_val = {got_val[30:0], ser_out_valid};
            if (cnt_out !== exp_cnt(nen)) cnt_ok = 1'b0;
            if (busy !== 1'b1 || ready !== 1'b0) busy_ok = 1'b0;
            nen++;
            load = (pulse_at >= 0 && nen == pulse_at);
         end else begin
            if ({ser_out, ser_out_valid, busy, ready, cnt_out} !== prev) hold_ok = 1'b0;
         end
         k++;
      end
      check({tag, "_edges"}, 32'(nen), 32'(FLEN));
      check({tag, "_ser"}, got_ser, exp_ser);
      check({tag, "_valid"}, got_val, exp_val);
      check({tag, "_cnt"}, 32'(cnt_ok), 32'd1);
      check({tag, "_busy"}, 32'(busy_ok), 32'd1);
      if (stretch) check({tag, "_hold"}, 32'(hold_ok), 32'd1);
      load   = 1'b0;
      clk_en = 1'b1;
      step();
      check({tag, "_end"}, {28'd0, ready, busy, ser_out_valid, ser_out}, 32'b1000);
      step();
      check({tag, "_idle"}, {29'd0, busy, ser_out_valid, ser_out}, 32'd0);
   endtask

   task automatic back_to_back();
      logic vals [0:63];
      logic sers [0:63];
      logic [31:0] f1;
      logic [31:0] f2;
      int run;
      bit seen_end;
      bit done;
      f1      = '0;
      f2      = '0;
      data_in = 8'hFF;
      load    = 1'b1;
      clk_en  = 1'b1;
      for (int e = 0; e <= 2 * FLEN + 1; e++) begin
         step();
         sers[e] = ser_out;
         vals[e] = ser_out_valid;
         if (e == 0) data_in = 8'h00;
         if (e == FLEN + 1) load = 1'b0;
      end
      for (int e = 0; e < FLEN; e++) begin
         f1 = {f1[30:0], sers[e]};
         f2 = {f2[30:0], sers[FLEN + 1 + e]};
      end
      check("b2b_frame1", f1, exp_frame(8'hFF));
      check("b2b_frame2", f2, exp_frame(8'h00));
      run      = 0;
      seen_end = 1'b0;
      done     = 1'b0;
      for (int e = 1; e <= 2 * FLEN; e++) begin
         if (!done) begin
            if (!seen_end && vals[e-1] && !vals[e]) seen_end = 1'b1;
            if (seen_end && !vals[e]) run++;
            if (seen_end && vals[e]) done = 1'b1;
         end
      end
      check("b2b_idle_bits", 32'(run), 32'(GAP + 1));
      check("b2b_ready_end", 32'(ready), 32'd1);
      step();
      check("b2b_no_third", {30'd0, busy, ser_out_valid}, 32'd0);
   endtask

   initial begin
      rst     = 1'b0;
      clk_en  = 1'b0;
      load    = 1'b0;
      data_in = '0;
      #12;
      check("rst_ser", 32'(ser_out), 32'd0);
      check("rst_valid", 32'(ser_out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_cnt", 32'(cnt_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step();

`ifdef FRAMER_PARITY_EN
      send_and_check("a5", 8'hA5, 32'h1AD28, 1'b0, -1);
      send_and_check("a4", 8'hA4, 32'h1AD24, 1'b0, -1);
      send_and_check("a5_stretch", 8'hA5, 32'h1AD28, 1'b1, -1);
`else
      send_and_check("a5", 8'hA5, 32'hD694, 1'b0, -1);
      send_and_check("a4", 8'hA4, 32'hD690, 1'b0, -1);
      send_and_check("a5_stretch", 8'hA5, 32'hD694, 1'b1, -1);
`endif
      // Load raised while payload bit 3 (edge 9) is on the line.
      send_and_check("ign_load", 8'h3C, exp_frame(8'h3C), 1'b0, 10);

      back_to_back();

      // Asynchronous reset while payload bit 4 is on ser_out.
      data_in = 8'hA5;
      load    = 1'b1;
      clk_en  = 1'b1;
      for (int e = 0; e <= 10; e++) begin
         step();
         load = 1'b0;
      end
      check("pre_rst_pay4", {27'd0, ser_out_valid, cnt_out}, {27'd0, 1'b1, 4'd4});
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_outputs", {24'd0, ser_out, ser_out_valid, busy, ready, cnt_out},
            {24'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
      step();
      @(negedge clk);
      rst = 1'b1;
      step();
      check("post_rst_idle", {29'd0, busy, ser_out_valid, ser_out}, 32'd0);
      send_and_check("x81", 8'h81, exp_frame(8'h81), 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/framer_110101.md
Name: framer_110101

Overview:
Serial frame transmitter; the sending end of the 110101 sync-pattern link.
- Accepts a parallel payload word through a load/ready handshake.
- Emits the header 1,1,0,1,0,1, then the payload MSB-first, then a guard gap of idle bits.
- Sits upstream of the serial link and drives stimulus and data into the pattern-detecting receiver.

Parameters:
PAYLOAD_W, 8, payload bits per frame; legal range 1..16 (bit index fits cnt_out).
GAP_LEN, 2, idle bit-times after each frame; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
clk_en  in  1  bit-time enable; all state advances only on clk edges with clk_en=1
load  in  1  request to send data_in
data_in  in  PAYLOAD_W  payload word
ready  out  1  high when a load will be accepted
ser_out  out  1  serial data, registered
ser_out_valid  out  1  high while ser_out carries a header, payload or parity bit
busy  out  1  high from acceptance through the last gap bit
cnt_out  out  4  index of the bit currently on ser_out within the current field

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ser_out=0, ser_out_valid=0, busy=0, ready=1, cnt_out=0, shift register cleared. A reset mid-frame aborts the frame immediately; no partial bits follow.
- States: IDLE -> HDR -> PAY -> [PAR] -> GAP -> IDLE.
- IDLE:
  - ready=1, ser_out=0, ser_out_valid=0.
  - Acceptance occurs on an edge with clk_en=1, load=1 and ready=1: data_in is captured and the state goes to HDR.
  - On that same edge, ser_out=1 (header bit 0), ser_out_valid=1 and cnt_out=0.
  - Latency from the acceptance edge to the first header bit on ser_out: 0 edges, because the output register updates on the acceptance edge itself.
- HDR: six bits 1,1,0,1,0,1 with cnt_out=0..5. After cnt_out=5, the next enabled edge moves to PAY with cnt_out=0 and ser_out=data[PAYLOAD_W-1].
- PAY:
  - PAYLOAD_W bits, MSB first, cnt_out=0..PAYLOAD_W-1.
  - After the last bit, the next enabled edge goes to PAR when PARITY_EN is defined, otherwise to GAP.
- GAP:
  - GAP_LEN bit-times with ser_out=0, ser_out_valid=0, busy=1, cnt_out=0..GAP_LEN-1.
  - After the last gap bit, the next enabled edge returns to IDLE.
- ready is high only in IDLE. load seen while busy is ignored and not queued; the requester must hold load until it sees ready.
- Back-to-back frames: load held high during the final gap bit is accepted on the edge that enters IDLE only if ready was already 1 at that edge. It is therefore accepted one bit-time after the gap ends, which means the minimum spacing is GAP_LEN+1 idle bits.
- clk_en=0: all registers, including the outputs, hold. A frame stretched by clk_en gaps is bit-identical to an unstretched one.
- Frame length in enabled edges: 6 + PAYLOAD_W (+1 with parity) + GAP_LEN.
- cnt_out resets to 0 at every field boundary and never exceeds 15.

Optional Feature:
FRAMER_PARITY_EN
- Defined: PAR state inserted after PAY. It emits one even-parity bit (XOR of all payload bits) with ser_out_valid=1 and cnt_out=0.
- Undefined: no PAR state and no parity bit; PAY goes directly to GAP.

Decomposition:
- Package framer_pkg holds:
  - state enum (IDLE, HDR, PAY, PAR, GAP);
  - HDR_PATTERN = 6'b110101;
  - HDR_LEN = 6.
- One sub-module, bit_counter:
  - 4-bit up-counter with clk_en, inc, clr and terminal-compare inputs;
  - carry-out co when the count equals the supplied terminal value.
  - The FSM uses co to end each field.
- The shift register and parity accumulator stay in the top level.

Test Plan:
- Reset: assert rst=0 mid-sim -> immediately ser_out=0, ser_out_valid=0, busy=0, ready=1, cnt_out=0.
- Single frame, data_in=8'hA5, clk_en=1:
  - ser_out = 110101 10100101 00 over 16 edges;
  - ser_out_valid high for exactly 14 edges;
  - ready returns to 1 on edge 16.
- Same frame with clk_en toggling 1,0,0,1,... -> identical bit sequence on enabled edges; outputs stable on disabled edges.
- load pulsed at payload bit 3 of a frame with data_in=8'h3C -> ignored; no second frame; busy drops on schedule.
- load held high with 8'hFF then 8'h00 -> two frames separated by 3 idle bits (GAP_LEN+1).
- rst pulsed during PAY bit 4 -> outputs reset asynchronously. The next load of 8'h81 sends a complete, correct frame.
- With FRAMER_PARITY_EN defined:
  - 8'hA5 -> parity bit 0 after the payload, frame of 17 edges;
  - 8'hA4 -> parity bit 1.
